// File: rtl/spcpu_mem_arbiter.sv
// spcpu_mem_arbiter: round-robin arbiter/sequencer sharing the
// single test-bench memory port between the CPU and a loader.
module spcpu_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              tb_clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              sz0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic              err0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              sz1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic              err1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_sz,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic              ptr;
  logic              cmd_sz;
  logic              cmd_we;
  logic              cmd_bad;
  logic              pick_ok;
  logic              pick;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_sz;
  logic              sel_we;
  logic              sel_bad;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    pick_ok = 1'b0;
    pick    = ptr;
    unique case (state)
      IDLE: begin
        pick_ok = req0 | req1;
        pick    = (req0 & req1) ? ptr : req1;
      end
      RESP: begin
        // served port still holds req here; only the other may chain
        pick    = ~grant_id;
        pick_ok = grant_id ? req0 : req1;
      end
      default: ;
    endcase
  end

  assign sel_addr  = pick ? addr1 : addr0;
  assign sel_sz    = pick ? sz1 : sz0;
  assign sel_we    = pick ? we1 : we0;
  assign sel_wdata = pick ? wdata1 : wdata0;
  assign sel_bad   = sel_sz & (sel_we | sel_addr[0]);

  assign rd_val = cmd_sz ? mem_rdata
                : {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};

  assign busy = (state != IDLE);

  always_ff @(posedge tb_clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      grant_id  <= 1'b0;
      cmd_sz    <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_bad   <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addr  <= '0;
      mem_sz    <= 1'b1;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      err0   <= 1'b0;
      err1   <= 1'b0;
      mem_we <= 1'b0;
      if (state == RESP) begin
        ptr <= ~grant_id;
        if (cmd_bad) begin
          err0 <= ~grant_id;
          err1 <= grant_id;
        end else begin
          ack0 <= ~grant_id;
          ack1 <= grant_id;
          if (!cmd_we) begin
            if (grant_id) rdata1 <= rd_val;
            else          rdata0 <= rd_val;
          end
        end
      end
      if (state == ACCESS) begin
        state <= RESP;
      end else if (pick_ok) begin
        grant_id <= pick;
        cmd_sz   <= sel_sz;
        cmd_we   <= sel_we;
        cmd_bad  <= sel_bad;
        state    <= sel_bad ? RESP : ACCESS;
        if (!sel_bad) begin
          mem_addr  <= sel_addr;
          mem_sz    <= sel_sz;
          mem_wdata <= sel_wdata;
          mem_we    <= sel_we;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule
